// File: rtl/stopwatch_hex.sv
// MM:SS:FF stopwatch with run/pause/lap control, driving six active-low 7-segment digits.
// The prescaler divides clk to TICK_HZ; each field keeps its own binary count below 100.
module stopwatch_hex #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned TICK_HZ  = 100,
  parameter int unsigned MIN_MAX  = 99,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clr,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [6:0]  SEG_ZERO  = 7'h40;
  localparam logic [6:0]  SEG_BLANK = 7'h7f;

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  state_t state, next_state;

  logic          start_q, lap_q, clr_q;
  logic          start_p, lap_p, clr_p;
  logic          frozen;
  logic [PW-1:0] presc;
  logic [6:0]    frac, sec, mins;
  logic [6:0]    lat_frac, lat_sec, lat_mins;
  logic [6:0]    d_frac, d_sec, d_mins;
  logic          count_en, tick, zero, capture, unfreeze;
  logic          roll_frac, roll_sec, roll_mins;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] tens(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  assign start_p = start_stop & ~start_q;
  assign lap_p   = lap & ~lap_q;
  assign clr_p   = clr & ~clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      lap_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      start_q <= start_stop;
      lap_q   <= lap;
      clr_q   <= clr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Resuming from PAUSE with a frozen display goes back to LAP so the freeze stays coherent.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!clr_p && start_p) next_state = RUN;
      RUN:     if (start_p) next_state = PAUSE;
               else if (lap_p) next_state = LAP;
      LAP:     if (start_p) next_state = PAUSE;
               else if (lap_p) next_state = RUN;
      PAUSE:   if (clr_p) next_state = IDLE;
               else if (start_p) next_state = frozen ? LAP : RUN;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    count_en = (state == RUN) || (state == LAP);
    zero     = clr_p && ((state == IDLE) || (state == PAUSE));
    capture  = (state == RUN) && (next_state == LAP);
    unfreeze = ((state == LAP) && (next_state == RUN)) ||
               ((state == PAUSE) && (next_state == PAUSE) && lap_p) ||
               zero;
  end

  assign tick      = count_en && (presc == PW'(DIV - 1));
  assign roll_frac = (frac == 7'(TICK_HZ - 1));
  assign roll_sec  = (sec == 7'd59);
  assign roll_mins = (mins == 7'(MIN_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      frozen   <= 1'b0;
      presc    <= '0;
      frac     <= '0;
      sec      <= '0;
      mins     <= '0;
      lat_frac <= '0;
      lat_sec  <= '0;
      lat_mins <= '0;
      running  <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      running <= (next_state == RUN) || (next_state == LAP);
      wrap    <= 1'b0;
      if (capture)       frozen <= 1'b1;
      else if (unfreeze) frozen <= 1'b0;
      if (zero) begin
        presc    <= '0;
        frac     <= '0;
        sec      <= '0;
        mins     <= '0;
        lat_frac <= '0;
        lat_sec  <= '0;
        lat_mins <= '0;
      end else begin
        if (capture) begin
          lat_frac <= frac;
          lat_sec  <= sec;
          lat_mins <= mins;
        end
        if (count_en) presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (!roll_frac) frac <= frac + 7'd1;
          else begin
            frac <= '0;
            if (!roll_sec) sec <= sec + 7'd1;
            else begin
              sec <= '0;
              if (!roll_mins) mins <= mins + 7'd1;
              else begin
                mins <= '0;
                wrap <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    d_frac = frozen ? lat_frac : frac;
    d_sec  = frozen ? lat_sec  : sec;
    d_mins = frozen ? lat_mins : mins;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      HEX0 <= SEG_ZERO;
      HEX1 <= SEG_ZERO;
      HEX2 <= SEG_ZERO;
      HEX3 <= SEG_ZERO;
      HEX4 <= SEG_ZERO;
      HEX5 <= BLANK_LZ ? SEG_BLANK : SEG_ZERO;
    end else begin
      HEX0 <= seg(ones(d_frac));
      HEX1 <= seg(tens(d_frac));
      HEX2 <= seg(ones(d_sec));
      HEX3 <= seg(tens(d_sec));
      HEX4 <= seg(ones(d_mins));
      HEX5 <= (BLANK_LZ && (d_mins < 7'd10)) ? SEG_BLANK : seg(tens(d_mins));
    end
  end

endmodule

// File: tb/tb_stopwatch_hex.sv
// Directed bench for stopwatch_hex: a vector table on a DIV=4, MIN_MAX=1 instance,
// then a hand-written minutes-blanking sequence on a DIV=1, MIN_MAX=99 instance.
module tb_stopwatch_hex;

  localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D3 = 7'h30, D5 = 7'h12;
  localparam logic [6:0] D8 = 7'h00, D9 = 7'h10, BL = 7'h7f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_stop, lap, clr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       running, wrap;

  logic       rst2, start2, lap2, clr2;
  logic [6:0] b0, b1, b2, b3, b4, b5;
  logic       running2, wrap2;

  stopwatch_hex #(.CLK_HZ(40), .TICK_HZ(10), .MIN_MAX(1), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clr(clr),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
    .running(running), .wrap(wrap)
  );

  stopwatch_hex #(.CLK_HZ(10), .TICK_HZ(10), .MIN_MAX(99), .BLANK_LZ(1'b1)) dut_blank (
    .clk(clk), .rst(rst2), .start_stop(start2), .lap(lap2), .clr(clr2),
    .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5),
    .running(running2), .wrap(wrap2)
  );

  typedef struct {
    logic        r, s, l, c;
    int unsigned cyc;
    logic [41:0] hex;
    logic        run, wrp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, s, l, c, input int unsigned n,
                     input logic [6:0] h5, h4, h3, h2, h1, h0, input logic run, w);
    vec_t v;
    v.r = r; v.s = s; v.l = l; v.c = c; v.cyc = n;
    v.hex = {h5, h4, h3, h2, h1, h0};
    v.run = run; v.wrp = w;
    vecs.push_back(v);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [41:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start_stop = 1'b0; lap = 1'b0; clr = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; lap2 = 1'b0; clr2 = 1'b0;

    //  r  s  l  c   cyc   HEX5 HEX4 HEX3 HEX2 HEX1 HEX0 run wrap
    add(1, 0, 0, 0,    2,  D0, D0, D0, D0, D0, D0, 0, 0); // reset state
    add(0, 1, 0, 0,    1,  D0, D0, D0, D0, D0, D0, 1, 0); // start
    add(0, 0, 0, 0,    4,  D0, D0, D0, D0, D0, D0, 1, 0); // tick just happened, pins lag
    add(0, 0, 0, 0,    1,  D0, D0, D0, D0, D0, D1, 1, 0); // FF=1 on pins
    add(0, 0, 0, 0,   35,  D0, D0, D0, D0, D0, D9, 1, 0); // FF=9
    add(0, 0, 0, 0,    1,  D0, D0, D0, D1, D0, D0, 1, 0); // carry into SS
    add(0, 0, 0, 0, 4756,  D0, D1, D5, D9, D0, D9, 1, 0); // 1:59:9
    add(0, 0, 0, 0,    2,  D0, D1, D5, D9, D0, D9, 1, 0);
    add(0, 0, 0, 0,    1,  D0, D1, D5, D9, D0, D9, 1, 1); // rollover edge
    add(0, 0, 0, 0,    1,  D0, D0, D0, D0, D0, D0, 1, 0); // wrap only one cycle
    add(0, 0, 0, 0,   12,  D0, D0, D0, D0, D0, D3, 1, 0); // FF=3
    add(0, 0, 1, 0,    1,  D0, D0, D0, D0, D0, D3, 1, 0); // lap freeze
    add(0, 0, 0, 0,   20,  D0, D0, D0, D0, D0, D3, 1, 0); // live FF=8, display frozen
    add(0, 0, 1, 0,    1,  D0, D0, D0, D0, D0, D3, 1, 0); // unfreeze, pins lag
    add(0, 0, 1, 0,    1,  D0, D0, D0, D0, D0, D8, 1, 0); // live again, held lap no re-edge
    add(0, 1, 0, 0,   20,  D0, D0, D0, D0, D0, D9, 0, 0); // held start: one pause only
    add(0, 0, 0, 0,    1,  D0, D0, D0, D0, D0, D9, 0, 0);
    add(0, 1, 0, 0,    1,  D0, D0, D0, D0, D0, D9, 1, 0); // resume
    add(0, 0, 0, 1,    1,  D0, D0, D0, D0, D0, D9, 1, 0); // clr while running
    add(0, 0, 0, 0,    3,  D0, D0, D0, D1, D0, D0, 1, 0); // count kept going
    add(0, 1, 0, 0,    1,  D0, D0, D0, D1, D0, D0, 0, 0); // pause
    add(0, 0, 0, 0,    1,  D0, D0, D0, D1, D0, D0, 0, 0);
    add(0, 1, 0, 1,    1,  D0, D0, D0, D1, D0, D0, 0, 0); // clr + start: clr wins
    add(0, 1, 0, 1,    1,  D0, D0, D0, D0, D0, D0, 0, 0);
    add(0, 0, 0, 0,    1,  D0, D0, D0, D0, D0, D0, 0, 0);
    add(0, 1, 0, 0,    1,  D0, D0, D0, D0, D0, D0, 1, 0); // start from IDLE
    add(0, 0, 0, 0,    4,  D0, D0, D0, D0, D0, D0, 1, 0); // prescaler was cleared
    add(0, 0, 0, 0,    1,  D0, D0, D0, D0, D0, D1, 1, 0);
    add(0, 0, 0, 0,  196,  D0, D0, D0, D5, D0, D0, 1, 0); // SS=5
    add(1, 0, 0, 0,    1,  D0, D0, D0, D0, D0, D0, 0, 0); // reset mid-run
    add(0, 0, 0, 0,    8,  D0, D0, D0, D0, D0, D0, 0, 0); // stays idle

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; start_stop = vecs[i].s; lap = vecs[i].l; clr = vecs[i].c;
      step(vecs[i].cyc);
      check("hex", i, {hex5, hex4, hex3, hex2, hex1, hex0}, vecs[i].hex);
      check("running", i, 42'(running), 42'(vecs[i].run));
      check("wrap", i, 42'(wrap), 42'(vecs[i].wrp));
    end

    // Leading-zero blanking on minutes: tick every clock on this instance.
    step(2);
    check("blank_reset", 0, {b5, b4, b3, b2, b1, b0}, {BL, D0, D0, D0, D0, D0});
    rst2 = 1'b0; start2 = 1'b1;
    step(1);
    check("blank_running", 1, 42'(running2), 42'(1'b1));
    start2 = 1'b0;
    step(101);
    check("blank_0m10s", 2, {b5, b4, b3, b2, b1, b0}, {BL, D0, D1, D0, D0, D0});
    step(5300);
    check("blank_9m", 3, {b5, b4, b3, b2, b1, b0}, {BL, D9, D0, D0, D0, D0});
    step(599);
    check("blank_9m59s9", 4, {b5, b4, b3, b2, b1, b0}, {BL, D9, D5, D9, D0, D9});
    step(1);
    check("blank_10m", 5, {b5, b4, b3, b2, b1, b0}, {D1, D0, D0, D0, D0, D0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
